// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone round-robin arbiter with per-cyc ownership lock
// and a stalled-strobe watchdog. Masters m0/m1 share slave port s_*.
module wb_rr_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [31:0] m0_wb_dat_i,
  output logic [31:0] m0_wb_dat_o,
  input  logic        m0_wb_we_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_cyc_i,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_err_o,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [31:0] m1_wb_dat_i,
  output logic [31:0] m1_wb_dat_o,
  input  logic        m1_wb_we_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_cyc_i,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_err_o,
  output logic [31:0] s_wb_adr_o,
  output logic [31:0] s_wb_dat_o,
  output logic        s_wb_we_o,
  output logic [3:0]  s_wb_sel_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_cyc_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_err_i,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [15:0] WDOG_MAX = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] wdog_q, wdog_d;
  logic        expire_q, expire_d;

  logic own0, own1, own_cyc, stalled, to_pulse;

  assign own0     = (state_q == OWN0);
  assign own1     = (state_q == OWN1);
  assign own_cyc  = (own0 & m0_wb_cyc_i) | (own1 & m1_wb_cyc_i);
  // Slave response in the expiry cycle beats the watchdog.
  assign to_pulse = expire_q & own_cyc & ~s_wb_ack_i & ~s_wb_err_i;
  assign stalled  = own_cyc & s_wb_stb_o & ~s_wb_ack_i & ~s_wb_err_i;
  assign o_grant  = {own1, own0};
  assign o_timeout = to_pulse;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      wdog_q   <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      wdog_q   <= wdog_d;
      expire_q <= expire_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i)
          state_d = last_q ? OWN0 : OWN1;
        else if (m0_wb_cyc_i)
          state_d = OWN0;
        else if (m1_wb_cyc_i)
          state_d = OWN1;
      end
      OWN0: begin
        if (!m0_wb_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      OWN1: begin
        if (!m1_wb_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Expiry is detected on the last stalled cycle and acted on
  // in the following cycle, so stb is seen for TIMEOUT_CYCLES.
  always_comb begin
    wdog_d   = '0;
    expire_d = 1'b0;
    if (stalled) begin
      if (wdog_q == WDOG_MAX)
        expire_d = 1'b1;
      else
        wdog_d = wdog_q + 16'd1;
    end
  end

  always_comb begin
    s_wb_adr_o  = '0;
    s_wb_dat_o  = '0;
    s_wb_we_o   = 1'b0;
    s_wb_sel_o  = '0;
    s_wb_stb_o  = 1'b0;
    s_wb_cyc_o  = 1'b0;
    m0_wb_dat_o = '0;
    m0_wb_ack_o = 1'b0;
    m0_wb_err_o = 1'b0;
    m1_wb_dat_o = '0;
    m1_wb_ack_o = 1'b0;
    m1_wb_err_o = 1'b0;
    unique case (1'b1)
      own0: begin
        s_wb_adr_o  = m0_wb_adr_i;
        s_wb_dat_o  = m0_wb_dat_i;
        s_wb_we_o   = m0_wb_we_i;
        s_wb_sel_o  = m0_wb_sel_i;
        s_wb_stb_o  = m0_wb_stb_i & ~expire_q;
        s_wb_cyc_o  = m0_wb_cyc_i;
        m0_wb_dat_o = s_wb_dat_i;
        m0_wb_ack_o = s_wb_ack_i;
        m0_wb_err_o = s_wb_err_i | to_pulse;
      end
      own1: begin
        s_wb_adr_o  = m1_wb_adr_i;
        s_wb_dat_o  = m1_wb_dat_i;
        s_wb_we_o   = m1_wb_we_i;
        s_wb_sel_o  = m1_wb_sel_i;
        s_wb_stb_o  = m1_wb_stb_i & ~expire_q;
        s_wb_cyc_o  = m1_wb_cyc_i;
        m1_wb_dat_o = s_wb_dat_i;
        m1_wb_ack_o = s_wb_ack_i;
        m1_wb_err_o = s_wb_err_i | to_pulse;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: table of per-cycle vectors
// plus a hand-written mid-transaction reset sequence.
module tb_wb_rr_arbiter;

  logic i_clk = 1'b0;
  logic i_resetn;
  always #5 i_clk = ~i_clk;

  logic [31:0] m0_adr, m0_wdat, m0_rdat, m1_adr, m1_wdat, m1_rdat;
  logic        m0_we, m0_stb, m0_cyc, m0_ack, m0_err;
  logic        m1_we, m1_stb, m1_cyc, m1_ack, m1_err;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic        s_we, s_stb, s_cyc, s_ack, s_err;
  logic [1:0]  grant;
  logic        tmo;

  wb_rr_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(i_clk), .i_resetn(i_resetn),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_wdat), .m0_wb_dat_o(m0_rdat),
    .m0_wb_we_i(m0_we), .m0_wb_sel_i(m0_sel), .m0_wb_stb_i(m0_stb),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_ack_o(m0_ack), .m0_wb_err_o(m0_err),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_wdat), .m1_wb_dat_o(m1_rdat),
    .m1_wb_we_i(m1_we), .m1_wb_sel_i(m1_sel), .m1_wb_stb_i(m1_stb),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_ack_o(m1_ack), .m1_wb_err_o(m1_err),
    .s_wb_adr_o(s_adr), .s_wb_dat_o(s_wdat), .s_wb_we_o(s_we),
    .s_wb_sel_o(s_sel), .s_wb_stb_o(s_stb), .s_wb_cyc_o(s_cyc),
    .s_wb_dat_i(s_rdat), .s_wb_ack_i(s_ack), .s_wb_err_i(s_err),
    .o_grant(grant), .o_timeout(tmo)
  );

  // in  = {c0,s0,c1,s1,ack,err}
  // out = {scyc,sstb,ack0,ack1,err0,err1,timeout}
  typedef struct packed {
    logic [5:0] in;
    logic [1:0] g;
    logic [6:0] out;
  } vec_t;

  vec_t tbl[$];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic void add(input logic [5:0] i, input logic [1:0] g,
                              input logic [6:0] o);
    tbl.push_back(vec_t'({i, g, o}));
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [31:0] e_adr, e_wd, e_d0, e_d1;
    logic [3:0]  e_sel;
    logic        e_we;

    // tie after reset: m0 first, bubble, m1, then m0 again
    add(6'b111100, 2'b00, 7'b0000000);
    add(6'b111100, 2'b01, 7'b1100000);
    add(6'b111110, 2'b01, 7'b1110000);
    add(6'b101100, 2'b01, 7'b1000000);
    add(6'b101100, 2'b01, 7'b1000000);
    add(6'b101100, 2'b01, 7'b1000000);
    add(6'b001100, 2'b01, 7'b0000000);
    add(6'b001100, 2'b00, 7'b0000000);
    add(6'b001100, 2'b10, 7'b1100000);
    add(6'b001110, 2'b10, 7'b1101000);
    add(6'b111000, 2'b10, 7'b1000000);
    add(6'b111000, 2'b10, 7'b1000000);
    add(6'b111000, 2'b10, 7'b1000000);
    add(6'b110000, 2'b10, 7'b0000000);
    add(6'b111100, 2'b00, 7'b0000000);
    add(6'b111110, 2'b01, 7'b1110000);
    add(6'b001100, 2'b01, 7'b0000000);
    add(6'b001100, 2'b00, 7'b0000000);
    // m1 owns with 3 strobes while m0 keeps requesting
    add(6'b111110, 2'b10, 7'b1101000);
    add(6'b111000, 2'b10, 7'b1000000);
    add(6'b111110, 2'b10, 7'b1101000);
    add(6'b111110, 2'b10, 7'b1101000);
    add(6'b111000, 2'b10, 7'b1000000);
    add(6'b110000, 2'b10, 7'b0000000);
    add(6'b110000, 2'b00, 7'b0000000);
    add(6'b110010, 2'b01, 7'b1110000);
    add(6'b000000, 2'b01, 7'b0000000);
    add(6'b000000, 2'b00, 7'b0000000);
    // m0 alone, slave acks 2 cycles after stb
    add(6'b110000, 2'b00, 7'b0000000);
    add(6'b110000, 2'b01, 7'b1100000);
    add(6'b110000, 2'b01, 7'b1100000);
    add(6'b110010, 2'b01, 7'b1110000);
    add(6'b100000, 2'b01, 7'b1000000);
    add(6'b000000, 2'b01, 7'b0000000);
    add(6'b000000, 2'b00, 7'b0000000);
    // watchdog expiry after 4 stalled cycles
    add(6'b110000, 2'b00, 7'b0000000);
    add(6'b110000, 2'b01, 7'b1100000);
    add(6'b110000, 2'b01, 7'b1100000);
    add(6'b110000, 2'b01, 7'b1100000);
    add(6'b110000, 2'b01, 7'b1100000);
    add(6'b110000, 2'b01, 7'b1000101);
    add(6'b110000, 2'b01, 7'b1100000);
    add(6'b110010, 2'b01, 7'b1110000);
    // ack on the 4th stalled cycle wins
    add(6'b110000, 2'b01, 7'b1100000);
    add(6'b110000, 2'b01, 7'b1100000);
    add(6'b110000, 2'b01, 7'b1100000);
    add(6'b110010, 2'b01, 7'b1110000);
    add(6'b110000, 2'b01, 7'b1100000);
    // cyc dropped mid-strobe, counter restarts from 0
    add(6'b000000, 2'b01, 7'b0000000);
    add(6'b000000, 2'b00, 7'b0000000);
    add(6'b110000, 2'b00, 7'b0000000);
    add(6'b110000, 2'b01, 7'b1100000);
    add(6'b110000, 2'b01, 7'b1100000);
    add(6'b110000, 2'b01, 7'b1100000);
    add(6'b110000, 2'b01, 7'b1100000);
    add(6'b110000, 2'b01, 7'b1000101);
    // slave err passes through without timeout
    add(6'b110001, 2'b01, 7'b1100100);
    add(6'b000000, 2'b01, 7'b0000000);
    add(6'b000000, 2'b00, 7'b0000000);

    m0_adr = 32'h10; m0_wdat = 32'hA5A5_0001; m0_we = 1'b1; m0_sel = 4'hF;
    m1_adr = 32'h20; m1_wdat = 32'h5A5A_0002; m1_we = 1'b0; m1_sel = 4'h3;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    s_ack = 1'b1; s_err = 1'b0; s_rdat = 32'hDEAD_BEEF;
    i_resetn = 1'b0;
    repeat (3) tick();
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_ctl", {25'd0, s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err, tmo},
        32'd0);
    chk("rst_adr", s_adr, 32'd0);
    i_resetn = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err} = tbl[k].in;
      s_rdat = 32'hCAFE_0000 | k;
      #1;
      chk($sformatf("row%0d_ctl", k),
          {23'd0, grant, s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err, tmo},
          {23'd0, tbl[k].g, tbl[k].out});
      e_adr = 32'd0; e_wd = 32'd0; e_we = 1'b0; e_sel = 4'h0;
      e_d0 = 32'd0; e_d1 = 32'd0;
      if (tbl[k].g == 2'b01) begin
        e_adr = 32'h10; e_wd = 32'hA5A5_0001; e_we = 1'b1; e_sel = 4'hF;
        e_d0 = 32'hCAFE_0000 | k;
      end else if (tbl[k].g == 2'b10) begin
        e_adr = 32'h20; e_wd = 32'h5A5A_0002; e_sel = 4'h3;
        e_d1 = 32'hCAFE_0000 | k;
      end
      chk($sformatf("row%0d_adr", k), s_adr, e_adr);
      chk($sformatf("row%0d_wdat", k), s_wdat, e_wd);
      chk($sformatf("row%0d_wesel", k), {27'd0, s_we, s_sel},
          {27'd0, e_we, e_sel});
      chk($sformatf("row%0d_rdat0", k), m0_rdat, e_d0);
      chk($sformatf("row%0d_rdat1", k), m1_rdat, e_d1);
      tick();
    end

    // reset asserted mid-strobe while m1 owns
    {m0_cyc, m0_stb, s_ack, s_err} = 4'b0000;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    #1;
    chk("mrst_idle", {30'd0, grant}, 32'd0);
    tick();
    chk("mrst_own1", {30'd0, grant}, 32'd2);
    chk("mrst_stb", {31'd0, s_stb}, 32'd1);
    chk("mrst_adr", s_adr, 32'h20);
    s_ack = 1'b1;
    i_resetn = 1'b0;
    #1;
    chk("mrst_grant0", {30'd0, grant}, 32'd0);
    chk("mrst_bus0", {28'd0, s_cyc, s_stb, m1_ack, m1_err}, 32'd0);
    chk("mrst_rdat0", m1_rdat, 32'd0);
    tick();
    s_ack = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    i_resetn = 1'b1;
    #1;
    chk("post_idle", {30'd0, grant}, 32'd0);
    tick();
    chk("post_tie_m0", {30'd0, grant}, 32'd1);
    chk("post_adr", s_adr, 32'h10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: stalled-strobe cycles before the watchdog error (range 1..65535).
REQ-002 SHALL have port i_clk, input, 1: single system clock; all logic is on the rising edge.
REQ-003 SHALL have port i_resetn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port mN_wb_adr_i (N=0,1), input, 32: master N address.
REQ-005 SHALL have port mN_wb_dat_i, input, 32: master N write data.
REQ-006 SHALL have port mN_wb_dat_o, output, 32: read data to master N.
REQ-007 SHALL have port mN_wb_we_i, input, 1: master N write enable.
REQ-008 SHALL have port mN_wb_sel_i, input, 4: master N byte select.
REQ-009 SHALL have port mN_wb_stb_i, input, 1: master N strobe.
REQ-010 SHALL have port mN_wb_cyc_i, input, 1: master N cycle request.
REQ-011 SHALL have port mN_wb_ack_o, output, 1: ack to master N.
REQ-012 SHALL have port mN_wb_err_o, output, 1: error to master N.
REQ-013 SHALL have ports s_wb_adr_o (32), s_wb_dat_o (32), s_wb_we_o (1), s_wb_sel_o (4), s_wb_stb_o (1) and s_wb_cyc_o (1), all outputs: the shared slave bus.
REQ-014 SHALL have ports s_wb_dat_i (32), s_wb_ack_i (1) and s_wb_err_i (1), all inputs: slave responses.
REQ-015 SHALL have port o_grant, output, 2: one-hot current owner (bit N = master N), 00 when idle.
REQ-016 SHALL have port o_timeout, output, 1: one-cycle pulse on a watchdog expiry.

Function
REQ-017 SHALL implement an FSM with states IDLE, OWN0 and OWN1 (owner register), plus a 1-bit last-owner pointer.
REQ-018 IDLE SHALL grant, at the next edge, the single requester whose cyc is high; if both cyc are high it SHALL grant the master that is not the last owner.
REQ-019 Grant latency SHALL be exactly 1 cycle from cyc high in IDLE to s_wb_cyc_o high.
REQ-020 In OWNn, the s_wb_* outputs SHALL be combinational copies of master N's signals, with s_wb_cyc_o = mN_wb_cyc_i.
REQ-021 In OWNn, mN_wb_ack_o, mN_wb_err_o and mN_wb_dat_o SHALL follow the slave; the non-owner SHALL see ack=0, err=0 and dat=0.
REQ-022 OWNn SHALL go to IDLE on the edge where mN_wb_cyc_i is low, setting last-owner to N.
REQ-023 There SHALL be a mandatory 1-cycle IDLE bubble between owners, with no direct OWN0<->OWN1 transition.
REQ-024 In IDLE, all s_wb_* outputs, all mN_wb_ack_o/err_o/dat_o and o_grant SHALL be 0.
REQ-025 The ownership lock SHALL be held for all of cyc, independent of stb, so back-to-back strobes within one cyc are never interleaved.
REQ-026 The watchdog SHALL be a 16-bit counter that increments each cycle s_wb_stb_o=1 and s_wb_ack_i=0 and s_wb_err_i=0, and clears otherwise.
REQ-027 When the counter equals TIMEOUT_CYCLES-1 while still stalled, the block SHALL, for one cycle, assert mN_wb_err_o to the owner, force s_wb_stb_o=0, pulse o_timeout and clear the counter; the grant SHALL be kept.
REQ-028 If the slave ack or err arrives in the same cycle as expiry, the slave response SHALL win, with no o_timeout and no forced err.
REQ-029 If a master drops cyc mid-strobe, the block SHALL release as in REQ-022 and clear the counter, with no error generated.
REQ-030 The watchdog SHALL NOT count in IDLE.
REQ-031 Slave err SHALL be passed through unchanged and SHALL NOT pulse o_timeout.

Reset
REQ-032 While i_resetn=0, the block SHALL asynchronously force state=IDLE, last-owner=1 (so m0 wins the first tie), watchdog=0, o_timeout=0 and every output to 0.
REQ-033 Reset asserted mid-transaction SHALL drop s_wb_cyc_o/stb_o immediately, with no ack or err delivered.
REQ-034 After reset release, the first grant SHALL follow REQ-018/019.

Verification
REQ-035 Stimulus: m0 cyc+stb (adr 0x10, we=1) alone; slave acks 2 cycles after stb -> s_wb_cyc_o high 1 cycle after m0 cyc; o_grant=01; m0 ack once; m1 ack stays 0.
REQ-036 Stimulus: m0 and m1 both raise cyc in the same cycle after reset, each holding cyc for 3 cycles after its ack -> grants m0, IDLE bubble, m1; on the next tie, m0 again.
REQ-037 Stimulus: m1 owns and m0 requests throughout, with m1 issuing 3 strobes in one cyc -> no m0 grant until m1 cyc drops; exactly 3 slave acks reach m1.
REQ-038 Stimulus: TIMEOUT_CYCLES=4, slave never acks m0 -> s_wb_stb_o high 4 cycles, then m0 err=1 and o_timeout=1 for 1 cycle with stb forced 0; o_grant stays 01.
REQ-039 Stimulus: TIMEOUT_CYCLES=4, slave ack on the 4th stalled cycle -> ack delivered; o_timeout and err stay 0.
REQ-040 Stimulus: i_resetn pulsed low mid-strobe while m1 owns -> all outputs 0 within the same cycle; after release, m0 wins a tie.
